i2s_capture_rx: RTL
===================

Name: i2s_capture_rx

Overview:
- Receive side of the codec serial audio link: deserializes ADC_SDATA into 24-bit left/right sample pairs.
- Uses the codec's BCLK/LRCLK (standard I2S, 1-bit delay, MSB first, LRCLK low = left).
- BCLK, LRCLK and ADC_SDATA are treated as asynchronous pins and oversampled in the system clock domain.
- Delivers each complete stereo pair over a valid/ready handshake to the recording/processing logic beside the music player sample path.

Parameters:
DATA_W, 24, bits captured per channel word (MSB first); extra bits in the slot are ignored.
SLOT_MAX, 32, maximum BCLK periods per channel slot; counter width is clog2(SLOT_MAX)+1.

Ports:
clk  input  1  system clock; frequency at least 4x BCLK.
reset  input  1  asynchronous, active-low reset.
BCLK  input  1  codec bit clock (asynchronous pin).
LRCLK  input  1  codec word select (asynchronous pin).
ADC_SDATA  input  1  codec serial ADC data (asynchronous pin).
rec_ready  input  1  consumer accepts the pair when high together with rec_valid.
rec_valid  output  1  pair available on rec_left/rec_right.
rec_left  output  DATA_W  left sample, two's complement.
rec_right  output  DATA_W  right sample, two's complement.
frame_error  output  1  sticky; set on a short word; cleared only by reset.
overrun_count  output  8  pairs dropped while an undelivered pair was held; saturates at 255.

Behaviour:
- Reset (reset=0, async): all outputs 0, state SYNC, all synchronizer and shift registers 0.
- Input conditioning: each pin passes through a 2-flop synchronizer plus one history flop.
- A BCLK rise is the cycle where sync2=1 and hist=0. All sampling happens only in that cycle. LRCLK and SDATA are taken from their sync2 stage.
- lr_prev holds the LRCLK value from the previous BCLK rise. lr_change = (sampled LRCLK != lr_prev).
- FSM runs on BCLK rises only:
  - SYNC: wait for an lr_change to LRCLK=0 (start of left), then go to DELAY-consumed, i.e. SHIFT with bit_cnt=0. Rises without that change are ignored. Never emits data.
  - SHIFT: shift SDATA into the MSB-first shift register and increment bit_cnt. At bit_cnt=DATA_W-1, store the word in the channel holding register (left or right per LRCLK), set that channel's done flag, then go to PAD.
  - PAD: ignore bits until lr_change.
  - Any state except SYNC, on lr_change: the rise carrying the change is the I2S delay bit and is discarded. bit_cnt=0, go to SHIFT for the new channel.
  - If lr_change arrives while in SHIFT with bit_cnt<DATA_W: set frame_error and discard the partial word. For a right-to-left change, also clear left_done.
  - If bit_cnt would exceed SLOT_MAX without lr_change: go to SYNC and set frame_error.
- Pair completion: the right word finishes with left_done=1. Clear both done flags. A right word with left_done=0 is discarded silently.
- Output register and handshake:
  - On pair completion with rec_valid=0 or (rec_valid and rec_ready) in the same cycle: load rec_left/rec_right and set rec_valid=1 on the next clk edge.
  - On pair completion with rec_valid=1 and rec_ready=0: drop the new pair, keep the held data unchanged, and increment overrun_count (saturating).
  - rec_valid falls the cycle after rec_valid && rec_ready unless a new pair loads in that same cycle.
  - rec_left/rec_right are stable while rec_valid=1 and rec_ready=0.
- Latency: rec_valid rises exactly 4 clk cycles after the pin BCLK rise that carries the right word's LSB (2 sync, 1 edge/FSM, 1 output register).
- Output is a single-entry buffer, no FIFO. Throughput is one pair per LRCLK period.

Test Plan:
- Reset, then 3 I2S frames (BCLK=clk/8, 32-bit slots) with L=24'h800001 and R=24'h7FFFFE, rec_ready=1 -> first frame after the initial LRCLK fall yields exactly one pair per frame with those values. Each rec_valid pulse is 1 cycle wide and lands 4 clk after the right LSB rise. frame_error=0.
- Same stream, rec_ready=0 for 3 frames, then 1 -> first pair is held unchanged, overrun_count=2, and the held (first) pair is delivered on release.
- Right slot truncated to 10 bits by an early LRCLK fall -> frame_error=1, no pair emitted for that frame, next full frame delivers correctly.
- Start stream mid-right-slot after reset -> no output until the first LRCLK fall; the first pair equals the first complete frame.
- Assert reset low mid-SHIFT with rec_valid=1 -> all outputs 0 immediately (asynchronous). After release, resync occurs and the next full frame is captured correctly.
- 260 overruns with rec_ready=0 -> overrun_count saturates at 255.

Source files
------------

// File: rtl/i2s_capture_rx.sv
// I2S receiver: oversamples BCLK/LRCLK/ADC_SDATA in the clk domain and delivers
// 24-bit left/right pairs through a single-entry valid/ready output register.
module i2s_capture_rx #(
  parameter int DATA_W   = 24,
  parameter int SLOT_MAX = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              BCLK,
  input  logic              LRCLK,
  input  logic              ADC_SDATA,
  input  logic              rec_ready,
  output logic              rec_valid,
  output logic [DATA_W-1:0] rec_left,
  output logic [DATA_W-1:0] rec_right,
  output logic              frame_error,
  output logic [7:0]        overrun_count
);

  localparam int CNT_W = $clog2(SLOT_MAX) + 1;

  typedef enum logic [1:0] {SYNC, SHIFT, PAD} state_t;

  logic              bclk_s1_q, bclk_s2_q, bclk_h_q, lr_s1_q, lr_s2_q, sd_s1_q, sd_s2_q;
  logic              bclk_s1_d, bclk_s2_d, bclk_h_d, lr_s1_d, lr_s2_d, sd_s1_d, sd_s2_d;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              chan_q, chan_d;
  logic              lr_prev_q, lr_prev_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] left_word_q, left_word_d, right_word_q, right_word_d;
  logic              left_done_q, left_done_d;
  logic              pair_done_q, pair_done_d;
  logic              frame_error_q, frame_error_d;
  logic              rec_valid_q, rec_valid_d;
  logic [DATA_W-1:0] rec_left_q, rec_left_d, rec_right_q, rec_right_d;
  logic [7:0]        overrun_q, overrun_d;

  logic bclk_rise, lr_change;

  assign bclk_rise = bclk_s2_q & ~bclk_h_q;
  assign lr_change = lr_s2_q ^ lr_prev_q;

  always_comb begin
    bclk_s1_d     = BCLK;
    bclk_s2_d     = bclk_s1_q;
    bclk_h_d      = bclk_s2_q;
    lr_s1_d       = LRCLK;
    lr_s2_d       = lr_s1_q;
    sd_s1_d       = ADC_SDATA;
    sd_s2_d       = sd_s1_q;
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    chan_d        = chan_q;
    lr_prev_d     = lr_prev_q;
    shift_d       = shift_q;
    left_word_d   = left_word_q;
    right_word_d  = right_word_q;
    left_done_d   = left_done_q;
    pair_done_d   = 1'b0;
    frame_error_d = frame_error_q;
    rec_valid_d   = rec_valid_q;
    rec_left_d    = rec_left_q;
    rec_right_d   = rec_right_q;
    overrun_d     = overrun_q;

    if (bclk_rise) begin
      lr_prev_d = lr_s2_q;
      if (state_q == SYNC) begin
        if (lr_change && !lr_s2_q) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          chan_d    = 1'b0;
        end
      end else if (lr_change) begin
        // The rise carrying the LRCLK change is the I2S delay bit: no data shifted.
        if (state_q == SHIFT) begin
          frame_error_d = 1'b1;
          if (!lr_s2_q) left_done_d = 1'b0;
        end
        state_d   = SHIFT;
        bit_cnt_d = '0;
        chan_d    = lr_s2_q;
      end else if (bit_cnt_q == CNT_W'(SLOT_MAX)) begin
        state_d       = SYNC;
        frame_error_d = 1'b1;
        left_done_d   = 1'b0;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (state_q == SHIFT) begin
          shift_d = {shift_q[DATA_W-2:0], sd_s2_q};
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = PAD;
            if (!chan_q) begin
              left_word_d = shift_d;
              left_done_d = 1'b1;
            end else begin
              right_word_d = shift_d;
              if (left_done_q) begin
                pair_done_d = 1'b1;
                left_done_d = 1'b0;
              end
            end
          end
        end
      end
    end

    if (pair_done_q) begin
      if (!rec_valid_q || rec_ready) begin
        rec_valid_d = 1'b1;
        rec_left_d  = left_word_q;
        rec_right_d = right_word_q;
      end else if (overrun_q != 8'hFF) begin
        overrun_d = overrun_q + 8'd1;
      end
    end else if (rec_valid_q && rec_ready) begin
      rec_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bclk_s1_q     <= 1'b0;
      bclk_s2_q     <= 1'b0;
      bclk_h_q      <= 1'b0;
      lr_s1_q       <= 1'b0;
      lr_s2_q       <= 1'b0;
      sd_s1_q       <= 1'b0;
      sd_s2_q       <= 1'b0;
      state_q       <= SYNC;
      bit_cnt_q     <= '0;
      chan_q        <= 1'b0;
      lr_prev_q     <= 1'b0;
      shift_q       <= '0;
      left_word_q   <= '0;
      right_word_q  <= '0;
      left_done_q   <= 1'b0;
      pair_done_q   <= 1'b0;
      frame_error_q <= 1'b0;
      rec_valid_q   <= 1'b0;
      rec_left_q    <= '0;
      rec_right_q   <= '0;
      overrun_q     <= '0;
    end else begin
      bclk_s1_q     <= bclk_s1_d;
      bclk_s2_q     <= bclk_s2_d;
      bclk_h_q      <= bclk_h_d;
      lr_s1_q       <= lr_s1_d;
      lr_s2_q       <= lr_s2_d;
      sd_s1_q       <= sd_s1_d;
      sd_s2_q       <= sd_s2_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      chan_q        <= chan_d;
      lr_prev_q     <= lr_prev_d;
      shift_q       <= shift_d;
      left_word_q   <= left_word_d;
      right_word_q  <= right_word_d;
      left_done_q   <= left_done_d;
      pair_done_q   <= pair_done_d;
      frame_error_q <= frame_error_d;
      rec_valid_q   <= rec_valid_d;
      rec_left_q    <= rec_left_d;
      rec_right_q   <= rec_right_d;
      overrun_q     <= overrun_d;
    end
  end

  assign rec_valid     = rec_valid_q;
  assign rec_left      = rec_left_q;
  assign rec_right     = rec_right_q;
  assign frame_error   = frame_error_q;
  assign overrun_count = overrun_q;

endmodule
